// File: rtl/fetch_pc_unit_if.sv
// Fetch-stage bundle: hazard/stall controls, EX redirect and BTB update,
// instruction memory address/data and the IF/ID outputs.
interface fetch_pc_unit_if;
    logic        stall;
    logic        IM_stall;
    logic        DM_stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic [31:0] IM_rdata;
    logic [31:0] IM_addr;
    logic [31:0] F_pc;
    logic [31:0] F_inst;
    logic        F_PredictTaken;

    modport master (
        output stall, IM_stall, DM_stall, redirect, redirect_pc,
        output upd_valid, upd_pc, upd_taken, upd_target, IM_rdata,
        input  IM_addr, F_pc, F_inst, F_PredictTaken
    );

    modport slave (
        input  stall, IM_stall, DM_stall, redirect, redirect_pc,
        input  upd_valid, upd_pc, upd_taken, upd_target, IM_rdata,
        output IM_addr, F_pc, F_inst, F_PredictTaken
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// Fetch PC owner: direct-mapped BTB with 2-bit counters for next-PC prediction,
// and a one-deep pending slot that holds an EX redirect across memory freezes.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BTB_ENTRIES = 16,
    parameter int          IDX_W       = $clog2(BTB_ENTRIES)
) (
    input logic            clk,
    input logic            rst,
    fetch_pc_unit_if.slave bus
);
    localparam int TAG_W = 30 - IDX_W;

    logic [31:0] r_pc;
    logic        r_pending_valid;
    logic [31:0] r_pending_pc;

    logic             w_btb_valid  [BTB_ENTRIES];
    logic [TAG_W-1:0] w_btb_tag    [BTB_ENTRIES];
    logic [31:0]      w_btb_target [BTB_ENTRIES];
    logic [1:0]       w_btb_cnt    [BTB_ENTRIES];

    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic             w_hit;
    logic             w_pred_taken;
    logic [31:0]      w_pred_next;
    logic             w_frozen;

    logic [IDX_W-1:0] w_upd_idx;
    logic [TAG_W-1:0] w_upd_tag;
    logic             w_upd_hit;
    logic             w_upd_en;

    assign w_idx        = r_pc[IDX_W+1:2];
    assign w_tag        = r_pc[31:IDX_W+2];
    assign w_hit        = w_btb_valid[w_idx] && (w_btb_tag[w_idx] == w_tag);
    assign w_pred_taken = w_hit && w_btb_cnt[w_idx][1];
    assign w_pred_next  = w_pred_taken ? w_btb_target[w_idx] : r_pc + 32'd4;
    assign w_frozen     = bus.IM_stall | bus.DM_stall;

    // Updates are dropped while frozen because EX re-presents the same request.
    assign w_upd_idx = bus.upd_pc[IDX_W+1:2];
    assign w_upd_tag = bus.upd_pc[31:IDX_W+2];
    assign w_upd_hit = w_btb_valid[w_upd_idx] && (w_btb_tag[w_upd_idx] == w_upd_tag);
    assign w_upd_en  = bus.upd_valid && !w_frozen;

    for (genvar gi = 0; gi < BTB_ENTRIES; gi++) begin : g_btb
        logic             r_valid;
        logic [TAG_W-1:0] r_tag;
        logic [31:0]      r_target;
        logic [1:0]       r_cnt;
        logic             w_sel;

        assign w_sel = w_upd_en && (w_upd_idx == IDX_W'(gi));

        always_ff @(posedge clk) begin
            if (rst) begin
                r_valid  <= 1'b0;
                r_tag    <= '0;
                r_target <= '0;
                r_cnt    <= 2'b01;
            end else if (w_sel) begin
                if (w_upd_hit) begin
                    if (bus.upd_taken) begin
                        r_target <= bus.upd_target;
                        if (r_cnt != 2'b11) r_cnt <= r_cnt + 2'b01;
                    end else if (r_cnt != 2'b00) begin
                        r_cnt <= r_cnt - 2'b01;
                    end
                end else if (bus.upd_taken) begin
                    r_valid  <= 1'b1;
                    r_tag    <= w_upd_tag;
                    r_target <= bus.upd_target;
                    r_cnt    <= 2'b10;
                end
            end
        end

        assign w_btb_valid[gi]  = r_valid;
        assign w_btb_tag[gi]    = r_tag;
        assign w_btb_target[gi] = r_target;
        assign w_btb_cnt[gi]    = r_cnt;
    end

    // Redirect beats load-use stall; a parked redirect is applied once unfrozen.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc            <= RESET_PC;
            r_pending_valid <= 1'b0;
            r_pending_pc    <= '0;
        end else if (w_frozen) begin
            if (bus.redirect) begin
                r_pending_valid <= 1'b1;
                r_pending_pc    <= bus.redirect_pc;
            end
        end else if (bus.redirect) begin
            r_pc            <= bus.redirect_pc;
            r_pending_valid <= 1'b0;
        end else if (r_pending_valid) begin
            r_pc            <= r_pending_pc;
            r_pending_valid <= 1'b0;
        end else if (!bus.stall) begin
            r_pc <= w_pred_next;
        end
    end

    assign bus.IM_addr        = r_pc;
    assign bus.F_pc           = r_pc;
    assign bus.F_inst         = bus.IM_rdata;
    assign bus.F_PredictTaken = w_pred_taken;
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed scenarios against fixed addresses, then
// randomized traffic against an address-level BTB/PC reference model.
module tb_fetch_pc_unit;
    localparam int          N      = 16;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_pc_unit_if bus ();

    fetch_pc_unit #(.RESET_PC(RST_PC), .BTB_ENTRIES(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int n_cyc  = 0;

    // Model keeps the full owner address of each slot instead of a tag field.
    logic [31:0] m_pc;
    logic        m_pend;
    logic [31:0] m_pend_pc;
    logic        m_v     [N];
    logic [31:0] m_owner [N];
    logic [31:0] m_tgt   [N];
    int          m_cnt   [N];

    function automatic int slot(input logic [31:0] a);
        return int'((a >> 2) % N);
    endfunction

    function automatic logic same_line(input logic [31:0] a, input logic [31:0] b);
        return (a / (4 * N)) == (b / (4 * N));
    endfunction

    function automatic logic m_pred(input logic [31:0] a);
        int s;
        s = slot(a);
        return m_v[s] && same_line(m_owner[s], a) && (m_cnt[s] >= 2);
    endfunction

    task automatic model_step();
        logic        frz;
        logic [31:0] nxt;
        int          s;
        frz = bus.IM_stall | bus.DM_stall;
        if (rst) begin
            m_pc      = RST_PC;
            m_pend    = 1'b0;
            m_pend_pc = '0;
            for (int k = 0; k < N; k++) begin
                m_v[k]   = 1'b0;
                m_cnt[k] = 1;
            end
            return;
        end
        nxt = m_pred(m_pc) ? m_tgt[slot(m_pc)] : m_pc + 32'd4;
        if (frz) begin
            if (bus.redirect) begin
                m_pend    = 1'b1;
                m_pend_pc = bus.redirect_pc;
            end
        end else if (bus.redirect) begin
            m_pc   = bus.redirect_pc;
            m_pend = 1'b0;
        end else if (m_pend) begin
            m_pc   = m_pend_pc;
            m_pend = 1'b0;
        end else if (!bus.stall) begin
            m_pc = nxt;
        end
        if (bus.upd_valid && !frz) begin
            s = slot(bus.upd_pc);
            if (m_v[s] && same_line(m_owner[s], bus.upd_pc)) begin
                if (bus.upd_taken) begin
                    m_cnt[s] = (m_cnt[s] == 3) ? 3 : m_cnt[s] + 1;
                    m_tgt[s] = bus.upd_target;
                end else begin
                    m_cnt[s] = (m_cnt[s] == 0) ? 0 : m_cnt[s] - 1;
                end
            end else if (bus.upd_taken) begin
                m_v[s]     = 1'b1;
                m_owner[s] = bus.upd_pc;
                m_tgt[s]   = bus.upd_target;
                m_cnt[s]   = 2;
            end
        end
    endtask

    task automatic idle();
        bus.stall       = 1'b0;
        bus.IM_stall    = 1'b0;
        bus.DM_stall    = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.upd_valid   = 1'b0;
        bus.upd_pc      = '0;
        bus.upd_taken   = 1'b0;
        bus.upd_target  = '0;
        bus.IM_rdata    = NOP;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        model_step();
        n_cyc++;
        $display("cycle %0d: IM_addr=%h pred=%0b inst=%h", n_cyc, bus.IM_addr,
                 bus.F_PredictTaken, bus.F_inst);
    endtask

    task automatic redirect_to(input logic [31:0] a);
        bus.redirect    = 1'b1;
        bus.redirect_pc = a;
        cyc();
        bus.redirect    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        cyc();
        cyc();
        n_cmp++;
        if (bus.IM_addr !== RST_PC) begin
            n_fail++;
            $display("FAIL reset_addr: got %h expected %h", bus.IM_addr, RST_PC);
        end
        n_cmp++;
        if (bus.F_pc !== RST_PC) begin
            n_fail++;
            $display("FAIL reset_fpc: got %h expected %h", bus.F_pc, RST_PC);
        end
        n_cmp++;
        if (bus.F_PredictTaken !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pred: got %b expected 0", bus.F_PredictTaken);
        end
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_a;
        for (int k = 1; k <= 3; k++) begin
            cyc();
            exp_a = 32'(k * 4);
            n_cmp++;
            if (bus.IM_addr !== exp_a || bus.F_PredictTaken !== 1'b0 || bus.F_inst !== NOP) begin
                n_fail++;
                $display("FAIL seq_%0d: got addr=%h pred=%b inst=%h expected addr=%h pred=0 inst=%h",
                         k, bus.IM_addr, bus.F_PredictTaken, bus.F_inst, exp_a, NOP);
            end
        end
    endtask

    task automatic test_btb_predict();
        bus.upd_valid  = 1'b1;
        bus.upd_pc     = 32'h10;
        bus.upd_taken  = 1'b1;
        bus.upd_target = 32'h100;
        cyc();
        idle();
        n_cmp++;
        if (bus.IM_addr !== 32'h10 || bus.F_PredictTaken !== 1'b1) begin
            n_fail++;
            $display("FAIL btb_hit: got addr=%h pred=%b expected addr=00000010 pred=1",
                     bus.IM_addr, bus.F_PredictTaken);
        end
        cyc();
        n_cmp++;
        if (bus.IM_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL btb_target: got %h expected 00000100", bus.IM_addr);
        end
        bus.upd_valid = 1'b1;
        bus.upd_pc    = 32'h10;
        bus.upd_taken = 1'b0;
        cyc();
        cyc();
        idle();
        redirect_to(32'h10);
        n_cmp++;
        if (bus.IM_addr !== 32'h10 || bus.F_PredictTaken !== 1'b0) begin
            n_fail++;
            $display("FAIL btb_weakened: got addr=%h pred=%b expected addr=00000010 pred=0",
                     bus.IM_addr, bus.F_PredictTaken);
        end
        cyc();
        n_cmp++;
        if (bus.IM_addr !== 32'h14) begin
            n_fail++;
            $display("FAIL btb_fallthrough: got %h expected 00000014", bus.IM_addr);
        end
        // counter should be at 0, so one taken update lifts it only to 1
        bus.upd_valid  = 1'b1;
        bus.upd_pc     = 32'h10;
        bus.upd_taken  = 1'b1;
        bus.upd_target = 32'h100;
        cyc();
        idle();
        redirect_to(32'h10);
        n_cmp++;
        if (bus.F_PredictTaken !== 1'b0) begin
            n_fail++;
            $display("FAIL btb_floor: got pred=%b expected 0", bus.F_PredictTaken);
        end
    endtask

    task automatic test_freeze_redirect();
        redirect_to(32'h40);
        bus.IM_stall    = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h200;
        for (int k = 0; k < 3; k++) begin
            cyc();
            bus.redirect = 1'b0;
            n_cmp++;
            if (bus.IM_addr !== 32'h40) begin
                n_fail++;
                $display("FAIL freeze_hold_%0d: got %h expected 00000040", k, bus.IM_addr);
            end
        end
        bus.IM_stall = 1'b0;
        cyc();
        n_cmp++;
        if (bus.IM_addr !== 32'h200) begin
            n_fail++;
            $display("FAIL freeze_release: got %h expected 00000200", bus.IM_addr);
        end
    endtask

    task automatic test_double_redirect();
        bus.DM_stall = 1'b1;
        redirect_to(32'h300);
        redirect_to(32'h400);
        cyc();
        n_cmp++;
        if (bus.IM_addr !== 32'h200) begin
            n_fail++;
            $display("FAIL dm_hold: got %h expected 00000200", bus.IM_addr);
        end
        bus.DM_stall = 1'b0;
        cyc();
        n_cmp++;
        if (bus.IM_addr !== 32'h400) begin
            n_fail++;
            $display("FAIL dm_last_wins: got %h expected 00000400", bus.IM_addr);
        end
        cyc();
        n_cmp++;
        if (bus.IM_addr !== 32'h404) begin
            n_fail++;
            $display("FAIL dm_no_stale: got %h expected 00000404", bus.IM_addr);
        end
    endtask

    task automatic test_stall();
        bus.stall = 1'b1;
        redirect_to(32'h500);
        n_cmp++;
        if (bus.IM_addr !== 32'h500) begin
            n_fail++;
            $display("FAIL stall_redirect: got %h expected 00000500", bus.IM_addr);
        end
        for (int k = 0; k < 2; k++) begin
            cyc();
            n_cmp++;
            if (bus.IM_addr !== 32'h500) begin
                n_fail++;
                $display("FAIL stall_hold_%0d: got %h expected 00000500", k, bus.IM_addr);
            end
        end
        bus.stall = 1'b0;
        cyc();
        n_cmp++;
        if (bus.IM_addr !== 32'h504) begin
            n_fail++;
            $display("FAIL stall_release: got %h expected 00000504", bus.IM_addr);
        end
    endtask

    task automatic test_wrap();
        redirect_to(32'hFFFF_FFFC);
        n_cmp++;
        if (bus.IM_addr !== 32'hFFFF_FFFC || bus.F_PredictTaken !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_top: got addr=%h pred=%b expected fffffffc pred=0",
                     bus.IM_addr, bus.F_PredictTaken);
        end
        cyc();
        n_cmp++;
        if (bus.IM_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_zero: got %h expected 00000000", bus.IM_addr);
        end
    endtask

    task automatic test_reset_pending();
        bus.IM_stall = 1'b1;
        redirect_to(32'h700);
        rst = 1'b1;
        cyc();
        n_cmp++;
        if (bus.IM_addr !== RST_PC) begin
            n_fail++;
            $display("FAIL rst_pending_addr: got %h expected %h", bus.IM_addr, RST_PC);
        end
        rst = 1'b0;
        bus.IM_stall = 1'b0;
        cyc();
        n_cmp++;
        if (bus.IM_addr !== RST_PC + 32'd4) begin
            n_fail++;
            $display("FAIL rst_pending_drop: got %h expected %h", bus.IM_addr, RST_PC + 32'd4);
        end
        redirect_to(32'h10);
        n_cmp++;
        if (bus.F_PredictTaken !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_btb_clear: got pred=%b expected 0", bus.F_PredictTaken);
        end
    endtask

    function automatic logic [31:0] rand_addr();
        return 32'($urandom_range(0, 47) * 4);
    endfunction

    task automatic test_random();
        logic [31:0] inst;
        for (int k = 0; k < 400; k++) begin
            rst             = ($urandom_range(0, 99) == 0);
            bus.stall       = ($urandom_range(0, 5) == 0);
            bus.IM_stall    = ($urandom_range(0, 5) == 0);
            bus.DM_stall    = ($urandom_range(0, 7) == 0);
            bus.redirect    = ($urandom_range(0, 7) == 0);
            bus.redirect_pc = rand_addr();
            bus.upd_valid   = ($urandom_range(0, 2) == 0);
            bus.upd_pc      = ($urandom_range(0, 3) == 0) ? m_pc : rand_addr();
            bus.upd_taken   = ($urandom_range(0, 2) != 0);
            bus.upd_target  = rand_addr();
            inst            = $urandom;
            bus.IM_rdata    = inst;
            cyc();
            n_cmp++;
            if (bus.IM_addr !== m_pc || bus.F_pc !== m_pc ||
                bus.F_PredictTaken !== m_pred(m_pc) || bus.F_inst !== inst) begin
                n_fail++;
                $display("FAIL rand_%0d: got addr=%h fpc=%h pred=%b inst=%h expected addr=%h pred=%b inst=%h",
                         k, bus.IM_addr, bus.F_pc, bus.F_PredictTaken, bus.F_inst,
                         m_pc, m_pred(m_pc), inst);
            end
        end
        rst = 1'b0;
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_sequential();
        test_btb_predict();
        test_freeze_redirect();
        test_double_redirect();
        test_stall();
        test_wrap();
        test_reset_pending();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
